// File: rtl/fp_mul_arbiter_if.sv
// Requester, multiplier and status signals of fp_mul_arbiter.
// The slave modport is the arbiter side. The master modport is the requester/multiplier side.
interface fp_mul_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_q;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_q;
  logic                  idle;
  logic [31:0]           busy_cycles;

  modport slave (
    input  req_valid, req_a, req_b, mul_q,
    output req_ready, mul_a, mul_b, resp_valid, resp_q, idle, busy_cycles
  );

  modport master (
    output req_valid, req_a, req_b, mul_q,
    input  req_ready, mul_a, mul_b, resp_valid, resp_q, idle, busy_cycles
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin issue of operand pairs to one shared pipelined FP multiplier, with tag tracking for result return.
// Optional issue counter on busy_cycles when FP_MUL_ARB_STATS_EN is defined.
module fp_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 5,
  localparam int unsigned TAG_W  = $clog2(NUM_REQ)
) (
  input logic             clk,
  input logic             areset,
  fp_mul_arbiter_if.slave bus
);

  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]   win;
  logic [TAG_W:0]     scan;
  logic [NUM_REQ-1:0] grant;
  logic               issue;
  logic [31:0]        mul_a_q, mul_b_q;
  logic [LATENCY-1:0] pv_q;
  logic [TAG_W-1:0]   ptag_q [LATENCY];
  logic [NUM_REQ-1:0] resp_valid_q;

  // The scan starts at rr_ptr and wraps modulo NUM_REQ. The first valid requester wins.
  always_comb begin
    scan  = '0;
    win   = '0;
    issue = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
      if (scan >= (TAG_W+1)'(NUM_REQ)) scan = scan - (TAG_W+1)'(NUM_REQ);
      if (!issue && bus.req_valid[scan[TAG_W-1:0]]) begin
        issue = 1'b1;
        win   = scan[TAG_W-1:0];
      end
    end
    grant    = issue ? (NUM_REQ'(1) << win) : '0;
    rr_ptr_d = (win == TAG_W'(NUM_REQ - 1)) ? '0 : win + TAG_W'(1);
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rr_ptr_q     <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      pv_q         <= '0;
      resp_valid_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) ptag_q[i] <= '0;
    end else begin
      if (issue) begin
        mul_a_q  <= bus.req_a[32*win +: 32];
        mul_b_q  <= bus.req_b[32*win +: 32];
        rr_ptr_q <= rr_ptr_d;
      end
      pv_q[0]   <= issue;
      ptag_q[0] <= win;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pv_q[i]   <= pv_q[i-1];
        ptag_q[i] <= ptag_q[i-1];
      end
      // The pipe tracks mul_a/mul_b, and mul_q lags them by one edge. This flop closes that gap.
      resp_valid_q <= pv_q[LATENCY-1] ? (NUM_REQ'(1) << ptag_q[LATENCY-1]) : '0;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_q     = bus.mul_q;
  assign bus.idle       = ~|pv_q && ~|resp_valid_q && ~|bus.req_valid;

`ifdef FP_MUL_ARB_STATS_EN
  logic [31:0] busy_q;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      busy_q <= '0;
    end else if (issue && (busy_q != '1)) begin
      busy_q <= busy_q + 32'd1;
    end
  end

  assign bus.busy_cycles = busy_q;
`else
  assign bus.busy_cycles = '0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a latency-matched multiplier model.
// The model handles operand pairs where one side is 2.0.
module tb_fp_mul_arbiter;
  localparam int unsigned NR  = 4;
  localparam int unsigned LAT = 5;

  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F4  = 32'h40800000;
  localparam logic [31:0] F5  = 32'h40A00000;
  localparam logic [31:0] F6  = 32'h40C00000;
  localparam logic [31:0] F8  = 32'h41000000;
  localparam logic [31:0] F10 = 32'h41200000;
  localparam logic [31:0] F12 = 32'h41400000;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.NUM_REQ(NR)) bus ();

  fp_mul_arbiter #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (b == F2) return a + 32'h00800000;
    if (a == F2) return b + 32'h00800000;
    return 32'hDEADBEEF;
  endfunction

  logic [31:0] mq [LAT];
  always @(posedge clk) begin
    mq[0] <= fmul(bus.mul_a, bus.mul_b);
    for (int i = 1; i < LAT; i++) mq[i] <= mq[i-1];
  end
  assign bus.mul_q = mq[LAT-1];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*idx +: 32] = a;
    bus.req_b[32*idx +: 32] = b;
  endtask

  task automatic do_reset();
    areset = 1'b0;
    #3;
    areset = 1'b1;
  endtask

  logic [31:0] rr_prod [4] = '{F2, F4, F6, F8};
  logic [31:0] b2b_a   [6] = '{F1, F2, F3, F4, F5, F6};
  logic [31:0] b2b_p   [6] = '{F2, F4, F6, F8, F10, F12};

  initial begin
    int j;
    areset        = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    tick();
    tick();

    // Values held while reset is asserted.
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_idle", 32'(bus.idle), 32'h1);
    chk("rst_mul_a", bus.mul_a, 32'h0);
    chk("rst_mul_b", bus.mul_b, 32'h0);
    chk("rst_busy", bus.busy_cycles, 32'h0);
    set_req(2, F2, F3);
    bus.req_valid = 4'b0100;
    #1;
    chk("rst_ready_comb", 32'(bus.req_ready), 32'h4);
    tick();
    chk("rst_no_issue", bus.mul_a, 32'h0);
    areset = 1'b1;

    // Single request: 2.0 * 3.0 from requester 2.
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    chk("single_idle_busy", 32'(bus.idle), 32'h0);
    tick();
    bus.req_valid = '0;
    chk("single_mul_a", bus.mul_a, F2);
    chk("single_mul_b", bus.mul_b, F3);
    for (int i = 1; i <= LAT; i++) begin
      tick();
      if (i == 2) chk("single_idle_inflight", 32'(bus.idle), 32'h0);
      if (i < LAT) begin
        chk("single_resp_early", 32'(bus.resp_valid), 32'h0);
      end else begin
        chk("single_resp_valid", 32'(bus.resp_valid), 32'h4);
        chk("single_resp_q", bus.resp_q, F6);
      end
    end
    tick();
    chk("single_resp_after", 32'(bus.resp_valid), 32'h0);
    chk("single_idle_after", 32'(bus.idle), 32'h1);

    // Round-robin: all four requesters valid for 8 cycles.
    do_reset();
    set_req(0, F1, F2);
    set_req(1, F2, F2);
    set_req(2, F3, F2);
    set_req(3, F4, F2);
    for (int c = 0; c < 8 + LAT; c++) begin
      bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) chk("rr_grant", 32'(bus.req_ready), 32'(1) << (c % 4));
      tick();
      j = c - LAT;
      if (j >= 0 && j < 8) begin
        chk("rr_resp_valid", 32'(bus.resp_valid), 32'(1) << (j % 4));
        chk("rr_resp_q", bus.resp_q, rr_prod[j % 4]);
      end else begin
        chk("rr_resp_none", 32'(bus.resp_valid), 32'h0);
      end
    end
    tick();

    // Sparse requests: one issue from requester 1 moves the pointer to 2. Then 1 and 3 alternate.
    bus.req_valid = 4'b0010;
    #1;
    chk("sparse_pre", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("sparse_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'h8 : 32'h2);
      tick();
    end
    bus.req_valid = '0;
    for (int i = 0; i <= LAT; i++) tick();
    chk("sparse_idle", 32'(bus.idle), 32'h1);

    // Back-to-back: requester 0 alone for 6 consecutive issues.
    for (int c = 0; c < 6 + LAT; c++) begin
      if (c < 6) begin
        set_req(0, b2b_a[c], F2);
        bus.req_valid = 4'b0001;
      end else begin
        bus.req_valid = '0;
      end
      #1;
      if (c < 6) chk("b2b_grant", 32'(bus.req_ready), 32'h1);
      tick();
      j = c - LAT;
      if (j >= 0 && j < 6) begin
        chk("b2b_resp_valid", 32'(bus.resp_valid), 32'h1);
        chk("b2b_resp_q", bus.resp_q, b2b_p[j]);
      end else begin
        chk("b2b_resp_none", 32'(bus.resp_valid), 32'h0);
      end
    end
    tick();

    // Reset asserted while three operations are in flight.
    for (int c = 0; c < 3; c++) begin
      set_req(0, b2b_a[c], F2);
      bus.req_valid = 4'b0001;
      tick();
    end
    bus.req_valid = '0;
    tick();
    areset = 1'b0;
    #1;
    chk("mid_rst_resp", 32'(bus.resp_valid), 32'h0);
    chk("mid_rst_mul_a", bus.mul_a, 32'h0);
    chk("mid_rst_mul_b", bus.mul_b, 32'h0);
    chk("mid_rst_idle", 32'(bus.idle), 32'h1);
    tick();
    areset = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk("mid_rst_no_resp", 32'(bus.resp_valid), 32'h0);
    end
    set_req(0, F3, F2);
    bus.req_valid = 4'b1111;
    #1;
    chk("mid_rst_ptr", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    for (int i = 1; i <= LAT; i++) tick();
    chk("fresh_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("fresh_resp_q", bus.resp_q, F6);
    tick();

    // Issue counter: 10 issues spread over 25 cycles.
    do_reset();
    chk("stats_reset", bus.busy_cycles, 32'h0);
    set_req(2, F1, F2);
    for (int c = 0; c < 25; c++) begin
      bus.req_valid = (c % 5 < 2) ? 4'b0100 : 4'b0000;
      tick();
    end
    bus.req_valid = '0;
`ifdef FP_MUL_ARB_STATS_EN
    chk("stats_count", bus.busy_cycles, 32'd10);
`else
    chk("stats_count", bus.busy_cycles, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
